// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants and FSM encoding for the MMIO bridge.
// Optional feature macro: MMIO_BUS_ERR_EN (bus-error flag + error counter).
package mmio_pkg;

   // Bridge transaction sequencing
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STROBE,
      ST_CAPTURE,
      ST_RESP
   } state_t;

   // addr[31:12] value that selects I/O space
   localparam logic [19:0] IO_PAGE_DEF = 20'h00400;

   // Device slot field inside the I/O page
   localparam int unsigned SLOT_LSB = 8;
   localparam int unsigned SLOT_MSB = 9;

   // Page offset of the bus-error counter
   localparam logic [11:0] ERR_CNT_OFS = 12'hC00;

endpackage

// File: rtl/mmio_bridge_if.sv
// mmio_bridge_if: core-side request/response bus of the MMIO bridge.
// master = core data port, slave = bridge.
interface mmio_bridge_if;

   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_rd;
   logic [3:0]  req_wstrb;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_addr, req_rd, req_wstrb, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_addr, req_rd, req_wstrb, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/mmio_addr_decode.sv
// mmio_addr_decode: combinational I/O address decode.
// Returns the device slot, whether it hits a populated device slot, and
// whether it hits the error counter (only when CNT_EN is set, which the top
// drives from MMIO_BUS_ERR_EN).
module mmio_addr_decode
   import mmio_pkg::*;
#(
   parameter logic [19:0] IO_PAGE = IO_PAGE_DEF,
   parameter int unsigned N_DEV   = 4,
   parameter bit          CNT_EN  = 1'b0
) (
   input  logic [31:0] addr,
   output logic [1:0]  slot,
   output logic        mapped,
   output logic        cnt_hit
);

   // Page match, zero sub-page field, slot within the populated range
   always_comb begin
      slot    = addr[SLOT_MSB:SLOT_LSB];
      mapped  = (addr[31:12] == IO_PAGE) && (addr[11:10] == 2'b00) &&
                ({1'b0, slot} < 3'(N_DEV));
      cnt_hit = CNT_EN && (addr[31:12] == IO_PAGE) && (addr[11:0] == ERR_CNT_OFS);
   end

endmodule

// File: rtl/mmio_bridge.sv
// mmio_bridge: single-outstanding bridge from the core data port to the
// I/O peripherals. One-cycle registered device strobes, registered read
// capture, one response beat per request.
// Optional feature macro: MMIO_BUS_ERR_EN -- unmapped accesses flag rsp_err
// and bump a 16-bit saturating counter readable at IO_PAGE offset 0xC00.
module mmio_bridge
   import mmio_pkg::*;
#(
   parameter logic [19:0] IO_PAGE = IO_PAGE_DEF,
   parameter int unsigned N_DEV   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   mmio_bridge_if.slave         core,
   output logic [31:0]          dev_addr,
   output logic [31:0]          dev_wdata,
   output logic [N_DEV-1:0]     dev_rd_strobe,
   output logic [4*N_DEV-1:0]   dev_wr_strobe,
   input  logic [32*N_DEV-1:0]  dev_rdata
);

`ifdef MMIO_BUS_ERR_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   state_t      state, state_nxt;
   logic [1:0]  dec_slot;
   logic        dec_mapped;
   logic        dec_cnt;
   logic        accept;
   logic        lat_rd;
   logic [1:0]  lat_slot;
   logic        lat_mapped;
   logic        lat_cnt;
   logic [31:0] sel_rdata;
   logic [15:0] err_cnt;

   mmio_addr_decode #(
      .IO_PAGE (IO_PAGE),
      .N_DEV   (N_DEV),
      .CNT_EN  (CNT_EN)
   ) u_decode (
      .addr    (core.req_addr),
      .slot    (dec_slot),
      .mapped  (dec_mapped),
      .cnt_hit (dec_cnt)
   );

   assign accept = core.req_valid && (state == ST_IDLE);

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next state plus handshake outputs; reads (mapped or not) pass CAPTURE
   always_comb begin
      state_nxt      = state;
      core.req_ready = 1'b0;
      core.rsp_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            core.req_ready = 1'b1;
            if (core.req_valid) state_nxt = ST_STROBE;
         end
         ST_STROBE:  state_nxt = lat_rd ? ST_CAPTURE : ST_RESP;
         ST_CAPTURE: state_nxt = ST_RESP;
         ST_RESP: begin
            core.rsp_valid = 1'b1;
            state_nxt      = ST_IDLE;
         end
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Request capture; strobes are loaded on accept so they are high exactly
   // during the STROBE cycle, and self-clear the cycle after
   always_ff @(posedge clk) begin
      if (rst) begin
         dev_addr      <= '0;
         dev_wdata     <= '0;
         dev_rd_strobe <= '0;
         dev_wr_strobe <= '0;
         lat_rd        <= 1'b0;
         lat_slot      <= '0;
         lat_mapped    <= 1'b0;
         lat_cnt       <= 1'b0;
      end else begin
         dev_rd_strobe <= '0;
         dev_wr_strobe <= '0;
         if (accept) begin
            dev_addr   <= core.req_addr;
            dev_wdata  <= core.req_wdata;
            lat_rd     <= core.req_rd;
            lat_slot   <= dec_slot;
            lat_mapped <= dec_mapped;
            lat_cnt    <= dec_cnt;
            if (dec_mapped) begin
               for (int unsigned i = 0; i < N_DEV; i++) begin
                  if (dec_slot == i[1:0]) begin
                     if (core.req_rd) dev_rd_strobe[i]       <= 1'b1;
                     else             dev_wr_strobe[4*i +: 4] <= core.req_wstrb;
                  end
               end
            end
         end
      end
   end

   // Select the addressed device's data_out bus
   always_comb begin
      sel_rdata = '0;
      for (int unsigned i = 0; i < N_DEV; i++) begin
         if (lat_slot == i[1:0]) sel_rdata = dev_rdata[32*i +: 32];
      end
   end

   // Response data: captured in CAPTURE for reads, cleared for writes, held otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         core.rsp_rdata <= '0;
      end else if (state == ST_CAPTURE) begin
         if (lat_cnt)         core.rsp_rdata <= {16'h0000, err_cnt};
         else if (lat_mapped) core.rsp_rdata <= sel_rdata;
         else                 core.rsp_rdata <= '0;
      end else if ((state == ST_STROBE) && !lat_rd) begin
         core.rsp_rdata <= '0;
      end
   end

`ifdef MMIO_BUS_ERR_EN
   // Saturating count of unmapped accesses, bumped once per access in STROBE
   always_ff @(posedge clk) begin
      if (rst)
         err_cnt <= '0;
      else if ((state == ST_STROBE) && !lat_mapped && !lat_cnt && (err_cnt != '1))
         err_cnt <= err_cnt + 16'd1;
   end

   assign core.rsp_err = (state == ST_RESP) && !lat_mapped && !lat_cnt;
`else
   assign err_cnt      = '0;
   assign core.rsp_err = 1'b0;
`endif

endmodule
